// File: rtl/btb_update_queue_pkg.sv
// Shared types for the BTB update path: the resolved-branch / BTB update record
// (same layout as ariane_pkg's branchpredict_t) and the queue sizing used at instantiation.
package btb_update_queue_pkg;

    localparam int unsigned VLEN          = 64;
    localparam int unsigned BTB_UPD_DEPTH = 8;
    localparam int unsigned BTB_UPD_PORTS = 2;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic [VLEN-1:0] target_address;
        logic            is_mispredict;
        logic            is_taken;
        logic            is_lower_16;
        logic            clear;
    } branchpredict_t;

    // A resolution carries new information for the BTB only when it was wrong or invalidates an entry.
    function automatic logic bp_wants_update(input branchpredict_t bp);
        return bp.is_mispredict | bp.clear;
    endfunction

endpackage

// File: rtl/btb_update_queue_compact.sv
// Prefix-sum over per-port eligibility: assigns consecutive slot offsets in port order
// and accepts only as many ports as there are free slots this cycle.
module btb_update_compact #(
    parameter int unsigned NR_PORTS = 2,
    parameter int unsigned PW       = 3,
    parameter int unsigned CW       = 4
) (
    input  logic [NR_PORTS-1:0]         eligible,
    input  logic [CW-1:0]               free,
    output logic [NR_PORTS-1:0]         accept,
    output logic [NR_PORTS-1:0][PW-1:0] offset,
    output logic [CW-1:0]               accepted,
    output logic [CW-1:0]               dropped
);

    logic [CW-1:0] run_s;

    // Walk ports oldest-first; lower ports win the remaining slots.
    always_comb begin
        run_s    = '0;
        accept   = '0;
        offset   = '0;
        dropped  = '0;
        accepted = '0;
        for (int p = 0; p < NR_PORTS; p++) begin
            offset[p] = run_s[PW-1:0];
            if (eligible[p] && (run_s < free)) begin
                accept[p] = 1'b1;
                run_s     = run_s + CW'(1);
            end else if (eligible[p]) begin
                dropped = dropped + CW'(1);
            end else begin
                accept[p] = 1'b0;
            end
        end
        accepted = run_s;
    end

endmodule

// File: rtl/btb_update_queue.sv
// Circular queue between the branch units and the single BTB update port; drains one entry per cycle.
// Optional build macro BTB_UPDATE_FILTER_EN: only mispredicted or clearing resolutions are queued.
module btb_update_queue
    import btb_update_queue_pkg::*;
#(
    parameter int unsigned DEPTH      = BTB_UPD_DEPTH,
    parameter int unsigned NR_PORTS   = BTB_UPD_PORTS,
    parameter int unsigned DROP_CNT_W = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               flush_i,
    input  branchpredict_t [NR_PORTS-1:0]      resolved_branch_i,
    output branchpredict_t                     branch_predict_o,
    output logic [$clog2(DEPTH):0]             count_o,
    output logic                               full_o,
    output logic                               empty_o,
    output logic [DROP_CNT_W-1:0]              drop_cnt_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = DROP_CNT_W + CW;

    branchpredict_t                 mem_r [DEPTH];
    logic [PW-1:0]                  rd_ptr_r;
    logic [PW-1:0]                  wr_ptr_r;
    logic [CW-1:0]                  count_r;
    logic [DROP_CNT_W-1:0]          drop_cnt_r;

    logic                           pop_s;
    logic [CW-1:0]                  free_s;
    logic [NR_PORTS-1:0]            eligible_s;
    logic [NR_PORTS-1:0]            accept_s;
    logic [NR_PORTS-1:0][PW-1:0]    offset_s;
    logic [CW-1:0]                  accepted_s;
    logic [CW-1:0]                  dropped_s;
    logic [PW-1:0]                  wr_idx_s [NR_PORTS];
    logic [SW-1:0]                  drop_sum_s;
    logic [DROP_CNT_W-1:0]          drop_cnt_next_s;

    // The BTB never stalls, so any occupied head is consumed this cycle.
    assign pop_s  = (count_r != '0);
    assign free_s = CW'(DEPTH) - count_r + CW'(pop_s);

    // Port eligibility; a flush discards inputs before they can be counted as drops.
    always_comb begin
        eligible_s = '0;
        for (int p = 0; p < NR_PORTS; p++) begin
`ifdef BTB_UPDATE_FILTER_EN
            eligible_s[p] = resolved_branch_i[p].valid & bp_wants_update(resolved_branch_i[p]) & ~flush_i;
`else
            eligible_s[p] = resolved_branch_i[p].valid & ~flush_i;
`endif
        end
    end

    btb_update_compact #(
        .NR_PORTS (NR_PORTS),
        .PW       (PW),
        .CW       (CW)
    ) i_compact (
        .eligible (eligible_s),
        .free     (free_s),
        .accept   (accept_s),
        .offset   (offset_s),
        .accepted (accepted_s),
        .dropped  (dropped_s)
    );

    // Slot addresses for the compacted ports.
    always_comb begin
        for (int p = 0; p < NR_PORTS; p++) begin
            wr_idx_s[p] = wr_ptr_r + offset_s[p];
        end
    end

    // Saturating drop counter next value.
    always_comb begin
        drop_sum_s = SW'(drop_cnt_r) + SW'(dropped_s);
        if (drop_sum_s > SW'({DROP_CNT_W{1'b1}})) begin
            drop_cnt_next_s = {DROP_CNT_W{1'b1}};
        end else begin
            drop_cnt_next_s = drop_sum_s[DROP_CNT_W-1:0];
        end
    end

    // Entry storage; deliberately not reset.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NR_PORTS; p++) begin
            if (accept_s[p]) begin
                mem_r[wr_idx_s[p]] <= resolved_branch_i[p];
            end
        end
    end

    // Pointers, occupancy and drop statistics.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            count_r    <= '0;
            drop_cnt_r <= '0;
        end else if (flush_i) begin
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            count_r    <= '0;
        end else begin
            rd_ptr_r   <= rd_ptr_r + PW'(pop_s);
            wr_ptr_r   <= wr_ptr_r + accepted_s[PW-1:0];
            count_r    <= count_r + accepted_s - CW'(pop_s);
            drop_cnt_r <= drop_cnt_next_s;
        end
    end

    // Head presentation; an empty queue shows an all-zero record.
    always_comb begin
        branch_predict_o = '0;
        if (pop_s) begin
            branch_predict_o       = mem_r[rd_ptr_r];
            branch_predict_o.valid = 1'b1;
        end else begin
            branch_predict_o = '0;
        end
    end

    assign count_o    = count_r;
    assign full_o     = (count_r == CW'(DEPTH));
    assign empty_o    = (count_r == '0);
    assign drop_cnt_o = drop_cnt_r;

endmodule

// File: tb/tb_btb_update_queue.sv
// Randomized bench for btb_update_queue with a queue-based reference model and directed pinning checks.
module tb_btb_update_queue;
    import btb_update_queue_pkg::*;

    localparam int unsigned DEPTH      = 8;
    localparam int unsigned NR_PORTS   = 2;
    localparam int unsigned DROP_CNT_W = 4;
    localparam int unsigned CW         = $clog2(DEPTH) + 1;
    localparam int          DMAX       = (1 << DROP_CNT_W) - 1;

    logic                          clk_i;
    logic                          rst_ni;
    logic                          flush_i;
    branchpredict_t [NR_PORTS-1:0] rb;
    branchpredict_t                branch_predict_o;
    logic [CW-1:0]                 count_o;
    logic                          full_o;
    logic                          empty_o;
    logic [DROP_CNT_W-1:0]         drop_cnt_o;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    branchpredict_t mq[$];
    int             mdrop;
    branchpredict_t exp_bp;

    btb_update_queue #(
        .DEPTH      (DEPTH),
        .NR_PORTS   (NR_PORTS),
        .DROP_CNT_W (DROP_CNT_W)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .flush_i           (flush_i),
        .resolved_branch_i (rb),
        .branch_predict_o  (branch_predict_o),
        .count_o           (count_o),
        .full_o            (full_o),
        .empty_o           (empty_o),
        .drop_cnt_o        (drop_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic bit model_eligible(input branchpredict_t b);
`ifdef BTB_UPDATE_FILTER_EN
        return b.valid && (b.is_mispredict || b.clear);
`else
        return b.valid;
`endif
    endfunction

    // Reference model: head leaves, then eligible ports join in order while room remains.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mq.delete();
            mdrop = 0;
        end else if (flush_i) begin
            mq.delete();
        end else begin
            if (mq.size() != 0) void'(mq.pop_front());
            for (int p = 0; p < NR_PORTS; p++) begin
                if (model_eligible(rb[p])) begin
                    if (mq.size() < DEPTH) mq.push_back(rb[p]);
                    else if (mdrop < DMAX) mdrop++;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk_i) begin
        if (chk_en) begin
            exp_bp = '0;
            if (mq.size() != 0) begin
                exp_bp       = mq[0];
                exp_bp.valid = 1'b1;
            end
            tests++;
            if (branch_predict_o !== exp_bp || count_o !== CW'(mq.size()) ||
                full_o !== (mq.size() == DEPTH) || empty_o !== (mq.size() == 0) ||
                drop_cnt_o !== DROP_CNT_W'(mdrop)) begin
                fails++;
                $display("FAIL cycle_cmp t=%0t: got v=%b pc=%h cnt=%0d full=%b empty=%b drop=%0d, need v=%b pc=%h cnt=%0d drop=%0d",
                         $time, branch_predict_o.valid, branch_predict_o.pc, count_o, full_o, empty_o,
                         drop_cnt_o, exp_bp.valid, exp_bp.pc, mq.size(), mdrop);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, need %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        flush_i = 1'b0;
        rb      = '0;
    endtask

    function automatic branchpredict_t mk(input logic [63:0] pc, input logic [63:0] tgt);
        branchpredict_t b;
        b                = '0;
        b.valid          = 1'b1;
        b.pc             = pc;
        b.target_address = tgt;
        b.is_taken       = 1'b1;
        b.is_mispredict  = 1'b1;
        return b;
    endfunction

    initial begin
        rst_ni = 1'b0;
        idle();
        tick();
        tick();
        chk("rst_valid", 64'(branch_predict_o.valid), 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_empty", 64'(empty_o), 64'd1);
        chk("rst_full", 64'(full_o), 64'd0);
        chk("rst_drop", 64'(drop_cnt_o), 64'd0);
        @(negedge clk_i);
        #1;
        rst_ni = 1'b1;
        chk_en = 1'b1;
        tick();

        // Single update: visible the next cycle, gone the one after.
        rb[0] = mk(64'h8000_0040, 64'h8000_0100);
        tick();
        idle();
        chk("single_valid", 64'(branch_predict_o.valid), 64'd1);
        chk("single_pc", branch_predict_o.pc, 64'h8000_0040);
        chk("single_tgt", branch_predict_o.target_address, 64'h8000_0100);
        chk("single_taken", 64'(branch_predict_o.is_taken), 64'd1);
        tick();
        chk("single_empty", 64'(empty_o), 64'd1);

        // Two ports in one cycle keep program order.
        rb[0] = mk(64'h100, 64'h180);
        rb[1] = mk(64'h200, 64'h280);
        tick();
        idle();
        chk("dual_pc0", branch_predict_o.pc, 64'h100);
        chk("dual_cnt2", 64'(count_o), 64'd2);
        tick();
        chk("dual_pc1", branch_predict_o.pc, 64'h200);
        chk("dual_cnt1", 64'(count_o), 64'd1);
        tick();
        chk("dual_cnt0", 64'(count_o), 64'd0);

        // Fill with pops in flight, then overflow by one.
        for (int i = 0; i < 7; i++) begin
            rb[0] = mk(64'h1000 + 64'(i * 8), 64'h9000);
            rb[1] = mk(64'h2000 + 64'(i * 8), 64'h9100);
            tick();
            chk("fill_cnt", 64'(count_o), 64'(i + 2));
        end
        chk("fill_full", 64'(full_o), 64'd1);
        chk("fill_drop0", 64'(drop_cnt_o), 64'd0);
        rb[0] = mk(64'h3000, 64'h9200);
        rb[1] = mk(64'h3008, 64'h9300);
        tick();
        idle();
        chk("ovf_cnt", 64'(count_o), 64'd8);
        chk("ovf_drop1", 64'(drop_cnt_o), 64'd1);

        // Flush with count 5: head still presented, inputs discarded without drop.
        tick();
        tick();
        tick();
        chk("pre_flush_cnt", 64'(count_o), 64'd5);
        flush_i = 1'b1;
        rb[0]   = mk(64'h4000, 64'h9400);
        #1;
        chk("flush_head_valid", 64'(branch_predict_o.valid), 64'd1);
        tick();
        idle();
        chk("flush_cnt", 64'(count_o), 64'd0);
        chk("flush_valid", 64'(branch_predict_o.valid), 64'd0);
        chk("flush_drop", 64'(drop_cnt_o), 64'd1);

        // Correctly predicted port 0 vs mispredicted port 1.
        rb[0]               = mk(64'h300, 64'h380);
        rb[0].is_mispredict = 1'b0;
        rb[1]               = mk(64'h304, 64'h384);
        tick();
        idle();
`ifdef BTB_UPDATE_FILTER_EN
        chk("filter_cnt", 64'(count_o), 64'd1);
        chk("filter_pc", branch_predict_o.pc, 64'h304);
`else
        chk("filter_cnt", 64'(count_o), 64'd2);
        chk("filter_pc", branch_predict_o.pc, 64'h300);
`endif
        tick();
        tick();

        // Sustained overflow saturates the drop counter.
        for (int i = 0; i < 30; i++) begin
            rb[0] = mk(64'h5000 + 64'(i * 16), 64'h9500);
            rb[1] = mk(64'h5008 + 64'(i * 16), 64'h9600);
            tick();
        end
        idle();
        chk("sat_drop", 64'(drop_cnt_o), 64'(DMAX));
        chk("sat_full", 64'(full_o), 64'd1);

        // Asynchronous reset mid-stream.
        @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        chk("arst_valid", 64'(branch_predict_o.valid), 64'd0);
        chk("arst_count", 64'(count_o), 64'd0);
        chk("arst_drop", 64'(drop_cnt_o), 64'd0);
        @(negedge clk_i);
        #1;
        rst_ni = 1'b1;
        tick();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            flush_i = ($urandom_range(0, 24) == 0);
            for (int p = 0; p < NR_PORTS; p++) begin
                rb[p]                = '0;
                rb[p].valid          = ($urandom_range(0, 3) != 0);
                rb[p].pc             = {32'h0, $urandom()};
                rb[p].target_address = {32'h0, $urandom()};
                rb[p].is_taken       = $urandom_range(0, 1) == 1;
                rb[p].is_lower_16    = $urandom_range(0, 1) == 1;
                rb[p].is_mispredict  = $urandom_range(0, 1) == 1;
                rb[p].clear          = ($urandom_range(0, 7) == 0);
            end
            tick();
        end
        idle();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
